// File: rtl/seq_mag_compare_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
// The optional early-exit build is selected with SEQ_MAG_COMPARE_EARLY_EXIT_EN.
package seq_mag_compare_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Plain constants of the state encoding for the FSM register.
    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_SCAN = S_SCAN;
    localparam logic [1:0] ST_DONE = S_DONE;

    typedef enum logic [1:0] {
        RES_EQ = 2'b00,
        RES_GT = 2'b01,
        RES_LT = 2'b10
    } res_e;

    function automatic int calc_chunks(input int width, input int digit);
        int n;
        if (digit > 0) begin
            n = width / digit;
        end else begin
            n = 1;
        end
        return n;
    endfunction

    function automatic int calc_idx_w(input int width, input int digit);
        int n;
        int w;
        n = calc_chunks(width, digit);
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    // Expands a result code into the {eq, ne, gt, lt} flag vector.
    function automatic logic [3:0] res_flags(input res_e r);
        logic [3:0] f;
        case (r)
            RES_EQ:  f = 4'b1000;
            RES_GT:  f = 4'b0110;
            RES_LT:  f = 4'b0101;
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/seq_mag_compare_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit chunk pair.
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] chunk_a_i,
    input  logic [DIGIT-1:0] chunk_b_i,
    output logic             chunk_gt_o,
    output logic             chunk_lt_o
);

    // Relational result of the chunk; both low when the chunks match.
    always_comb begin
        chunk_gt_o = 1'b0;
        chunk_lt_o = 1'b0;
        if (chunk_a_i > chunk_b_i) begin
            chunk_gt_o = 1'b1;
        end else if (chunk_a_i < chunk_b_i) begin
            chunk_lt_o = 1'b1;
        end else begin
            chunk_gt_o = 1'b0;
            chunk_lt_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, signed-capable.
// Define SEQ_MAG_COMPARE_EARLY_EXIT_EN to stop scanning at the first differing chunk.
module seq_mag_compare
    import seq_mag_compare_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             ne,
    output logic             gt,
    output logic             lt
);

    localparam int N     = calc_chunks(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(WIDTH, DIGIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    // Flipping the sign bit maps two's complement onto offset binary.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

`ifdef SEQ_MAG_COMPARE_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_mag_compare: WIDTH must be a positive multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_acc_q, gt_acc_d;
    logic             lt_acc_q, lt_acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       flags_q, flags_d;

    logic [DIGIT-1:0] chunk_a_s;
    logic [DIGIT-1:0] chunk_b_s;
    logic             chunk_gt_s;
    logic             chunk_lt_s;
    logic             rec_gt_s;
    logic             rec_lt_s;
    logic             scan_exit_s;
    res_e             res_s;

    // Selects the chunk pair addressed by the scan index.
    always_comb begin
        chunk_a_s = {DIGIT{1'b0}};
        chunk_b_s = {DIGIT{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == idx_q) begin
                chunk_a_s = a_q[i*DIGIT +: DIGIT];
                chunk_b_s = b_q[i*DIGIT +: DIGIT];
            end else begin
                chunk_a_s = chunk_a_s;
                chunk_b_s = chunk_b_s;
            end
        end
    end

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .chunk_a_i  (chunk_a_s),
        .chunk_b_i  (chunk_b_s),
        .chunk_gt_o (chunk_gt_s),
        .chunk_lt_o (chunk_lt_s)
    );

    // The first recorded difference wins; lower chunks cannot override it.
    always_comb begin
        rec_gt_s    = gt_acc_q | (~(gt_acc_q | lt_acc_q) & chunk_gt_s);
        rec_lt_s    = lt_acc_q | (~(gt_acc_q | lt_acc_q) & chunk_lt_s);
        scan_exit_s = (idx_q == IDX_ZERO) | (EARLY_EXIT & (chunk_gt_s | chunk_lt_s));
        if (rec_gt_s) begin
            res_s = RES_GT;
        end else if (rec_lt_s) begin
            res_s = RES_LT;
        end else begin
            res_s = RES_EQ;
        end
    end

    // Next-state logic for the IDLE/SCAN/DONE sequencer and its registered outputs.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        gt_acc_d = gt_acc_q;
        lt_acc_d = lt_acc_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d      = a ^ (is_signed ? MSB_MASK : {WIDTH{1'b0}});
                    b_d      = b ^ (is_signed ? MSB_MASK : {WIDTH{1'b0}});
                    idx_d    = IDX_LAST;
                    gt_acc_d = 1'b0;
                    lt_acc_d = 1'b0;
                    state_d  = ST_SCAN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                gt_acc_d = rec_gt_s;
                lt_acc_d = rec_lt_s;
                if (scan_exit_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    flags_d = res_flags(res_s);
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = IDX_ZERO;
                gt_acc_d = 1'b0;
                lt_acc_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            idx_q    <= IDX_ZERO;
            gt_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            gt_acc_q <= gt_acc_d;
            lt_acc_q <= lt_acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flags_q  <= flags_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = flags_q[3];
    assign ne   = flags_q[2];
    assign gt   = flags_q[1];
    assign lt   = flags_q[0];

endmodule
